// File: rtl/router_port_rx.sv
// router_port_rx: drains one router output-port FIFO, parses header/payload/parity
// packets, streams payload bytes and reports end-of-packet status.
module router_port_rx #(
    parameter int unsigned TIMEOUT = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       vld_out,
    input  logic [7:0] data_out,
    input  logic       hold,
    output logic       read_enb,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [1:0] pkt_addr,
    output logic [5:0] pkt_len,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       pkt_abort,
    output logic       rx_busy
);

    localparam int unsigned LEN_W = 6;
    localparam int unsigned CNT_W = 6;

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] HDR_WAIT    = 3'd1;
    localparam logic [2:0] PAYLOAD     = 3'd2;
    localparam logic [2:0] PARITY_WAIT = 3'd3;
    localparam logic [2:0] DONE        = 3'd4;

    logic [2:0]       state_q,      state_d;
    logic [LEN_W-1:0] pkt_len_q,    pkt_len_d;
    logic [1:0]       pkt_addr_q,   pkt_addr_d;
    logic [7:0]       acc_q,        acc_d;
    logic [LEN_W-1:0] issued_q,     issued_d;
    logic [CNT_W-1:0] starve_q,     starve_d;
    logic             rd_pend_q,    rd_pend_d;
    logic             rd_par_q,     rd_par_d;
    logic             par_issued_q, par_issued_d;
    logic [7:0]       byte_out_q,   byte_out_d;
    logic             byte_valid_q, byte_valid_d;
    logic             pkt_done_q,   pkt_done_d;
    logic             parity_err_q, parity_err_d;
    logic             pkt_abort_q,  pkt_abort_d;
    logic             rx_busy_q,    rx_busy_d;

    logic             can_read;
    logic [CNT_W-1:0] starve_inc;

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pkt_len_q    <= '0;
            pkt_addr_q   <= '0;
            acc_q        <= '0;
            issued_q     <= '0;
            starve_q     <= '0;
            rd_pend_q    <= 1'b0;
            rd_par_q     <= 1'b0;
            par_issued_q <= 1'b0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            pkt_abort_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pkt_len_q    <= pkt_len_d;
            pkt_addr_q   <= pkt_addr_d;
            acc_q        <= acc_d;
            issued_q     <= issued_d;
            starve_q     <= starve_d;
            rd_pend_q    <= rd_pend_d;
            rd_par_q     <= rd_par_d;
            par_issued_q <= par_issued_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            pkt_done_q   <= pkt_done_d;
            parity_err_q <= parity_err_d;
            pkt_abort_q  <= pkt_abort_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    // Next-state, read strobe, capture and status pulses
    always_comb begin
        state_d      = state_q;
        pkt_len_d    = pkt_len_q;
        pkt_addr_d   = pkt_addr_q;
        acc_d        = acc_q;
        issued_d     = issued_q;
        starve_d     = starve_q;
        rd_pend_d    = 1'b0;
        rd_par_d     = 1'b0;
        par_issued_d = par_issued_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        pkt_done_d   = 1'b0;
        parity_err_d = 1'b0;
        pkt_abort_d  = 1'b0;
        read_enb     = 1'b0;

        can_read   = vld_out & ~hold & ~reset;
        starve_inc = starve_q + CNT_W'(1);

        // A payload read issued last cycle lands on data_out now
        if (rd_pend_q && !rd_par_q) begin
            byte_out_d   = data_out;
            byte_valid_d = 1'b1;
            acc_d        = acc_q ^ data_out;
        end

        case (state_q)
            IDLE: begin
                read_enb = can_read;
                if (can_read) state_d = HDR_WAIT;
            end

            HDR_WAIT: begin
                pkt_len_d    = data_out[7:2];
                pkt_addr_d   = data_out[1:0];
                acc_d        = data_out;
                issued_d     = '0;
                starve_d     = '0;
                par_issued_d = 1'b0;
                state_d      = (data_out[7:2] != '0) ? PAYLOAD : PARITY_WAIT;
            end

            PAYLOAD: begin
                read_enb = can_read & (issued_q < pkt_len_q);
                if (read_enb) begin
                    issued_d  = issued_q + LEN_W'(1);
                    rd_pend_d = 1'b1;
                    starve_d  = '0;
                    if (issued_q + LEN_W'(1) == pkt_len_q) state_d = PARITY_WAIT;
                end else if (hold) begin
                    starve_d = '0;
                end else begin
                    starve_d = starve_inc;
                    if (starve_inc == CNT_W'(TIMEOUT)) begin
                        state_d     = DONE;
                        pkt_done_d  = 1'b1;
                        pkt_abort_d = 1'b1;
                    end
                end
            end

            PARITY_WAIT: begin
                if (!par_issued_q) begin
                    read_enb = can_read;
                    if (can_read) begin
                        par_issued_d = 1'b1;
                        rd_pend_d    = 1'b1;
                        rd_par_d     = 1'b1;
                        starve_d     = '0;
                    end else if (hold) begin
                        starve_d = '0;
                    end else begin
                        starve_d = starve_inc;
                        if (starve_inc == CNT_W'(TIMEOUT)) begin
                            state_d     = DONE;
                            pkt_done_d  = 1'b1;
                            pkt_abort_d = 1'b1;
                        end
                    end
                end else if (rd_pend_q && rd_par_q) begin
                    state_d      = DONE;
                    pkt_done_d   = 1'b1;
                    parity_err_d = (acc_q != data_out);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        rx_busy_d = (state_d != IDLE);
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign pkt_addr   = pkt_addr_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_done   = pkt_done_q;
    assign parity_err = parity_err_q;
    assign pkt_abort  = pkt_abort_q;
    assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_router_port_rx.sv
// Bench for router_port_rx: FIFO model feeds packets, a packet-level reference
// predicts the byte stream and status of each packet.
module tb_router_port_rx;

    localparam int unsigned TIMEOUT = 24;
    localparam int          BUDGET  = 300;

    logic       clock;
    logic       reset;
    logic       vld_out;
    logic [7:0] data_out;
    logic       hold;
    logic       read_enb;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [1:0] pkt_addr;
    logic [5:0] pkt_len;
    logic       pkt_done;
    logic       parity_err;
    logic       pkt_abort;
    logic       rx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fifo[$];

    router_port_rx #(.TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .hold       (hold),
        .read_enb   (read_enb),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .pkt_addr   (pkt_addr),
        .pkt_len    (pkt_len),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .pkt_abort  (pkt_abort),
        .rx_busy    (rx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Router FIFO: registered read, data valid the cycle after read_enb
    always @(posedge clock) begin
        if (read_enb && fifo.size() > 0) data_out <= fifo.pop_front();
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // mode: 0 free-running, 1 hold window after evt_at payload reads,
    //       2 starve after evt_at payload reads, 3 random hold/vld gaps
    task automatic run_pkt(input int len, input int addr, input bit corrupt, input int mode,
                           input int evt_at, input bit fixed_pl, input bit chk_lat);
        logic [7:0] pl[$];
        logic [7:0] hdr, par, b;
        int  got[$];
        int  reads, cyc, c0, cd, hold_left, exp_n, idle_rd;
        bit  done, bad, hold_used, vld_en, exp_abort, seen_pe, seen_pa;

        hdr = {6'(len), 2'(addr)};
        par = hdr;
        for (int i = 0; i < len; i++) begin
            b = fixed_pl ? 8'(17 * (i + 1)) : 8'($urandom);
            pl.push_back(b);
            par ^= b;
        end
        if (corrupt) par ^= 8'h01;
        fifo.push_back(hdr);
        foreach (pl[i]) fifo.push_back(pl[i]);
        fifo.push_back(par);

        exp_abort = (mode == 2);
        exp_n     = exp_abort ? evt_at : len;
        reads = 0; cyc = 0; c0 = 0; cd = 0; hold_left = 0;
        done = 0; bad = 0; hold_used = 0; seen_pe = 0; seen_pa = 0;

        while (!done && cyc < BUDGET) begin
            @(negedge clock);
            if (byte_valid) got.push_back(int'(byte_out));
            if (pkt_done) begin
                done = 1; cd = cyc; seen_pe = parity_err; seen_pa = pkt_abort;
            end
            vld_en = 1'b1;
            hold   = 1'b0;
            case (mode)
                1: begin
                    if (!hold_used && reads == evt_at + 1) begin
                        hold_used = 1; hold_left = 4;
                    end
                    if (hold_left > 0) begin
                        hold = 1'b1; hold_left--;
                    end
                end
                2: vld_en = (reads < evt_at + 1);
                3: begin
                    hold   = ($urandom_range(0, 3) == 0);
                    vld_en = ($urandom_range(0, 3) != 0);
                end
                default: ;
            endcase
            if (done) vld_en = 1'b0;
            vld_out = vld_en && (fifo.size() > 0);
            #1;
            if (read_enb) begin
                if (hold || !vld_out) bad = 1;
                if (reads == 0) c0 = cyc;
                reads++;
            end
            cyc++;
        end

        check("pkt_done_seen", int'(done), 1);
        check("byte_count", got.size(), exp_n);
        for (int i = 0; i < exp_n && i < got.size(); i++)
            check($sformatf("byte[%0d]", i), got[i], int'(pl[i]));
        check("parity_err", int'(seen_pe), exp_abort ? 0 : int'(corrupt));
        check("pkt_abort", int'(seen_pa), int'(exp_abort));
        check("read_count", reads, exp_abort ? evt_at + 1 : len + 2);
        check("read_qualify", int'(bad), 0);
        if (chk_lat) check("latency", cd - c0, len + 4);

        // Idle gap: no reads with nothing offered, header fields persist
        vld_out = 1'b0;
        hold    = 1'b0;
        if (exp_abort) fifo.delete();
        idle_rd = 0;
        repeat (3) begin
            @(negedge clock);
            #1;
            if (read_enb) idle_rd++;
        end
        check("idle_reads", idle_rd, 0);
        check("rx_busy_idle", int'(rx_busy), 0);
        check("pkt_addr", int'(pkt_addr), addr);
        check("pkt_len", int'(pkt_len), len);
    endtask

    initial begin
        int nb, cyc, done_cnt;
        reset    = 1'b1;
        vld_out  = 1'b1;
        hold     = 1'b0;
        data_out = 8'h00;
        repeat (2) @(negedge clock);
        #1;
        check("rst_read_enb", int'(read_enb), 0);
        check("rst_byte_valid", int'(byte_valid), 0);
        check("rst_pkt_done", int'(pkt_done), 0);
        check("rst_parity_err", int'(parity_err), 0);
        check("rst_pkt_abort", int'(pkt_abort), 0);
        check("rst_rx_busy", int'(rx_busy), 0);
        check("rst_byte_out", int'(byte_out), 0);
        check("rst_pkt_addr", int'(pkt_addr), 0);
        check("rst_pkt_len", int'(pkt_len), 0);
        vld_out = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        run_pkt(3, 1, 1'b0, 0, 0, 1'b1, 1'b1);
        run_pkt(3, 1, 1'b1, 0, 0, 1'b1, 1'b1);
        run_pkt(0, 2, 1'b0, 0, 0, 1'b0, 1'b1);
        run_pkt(5, 3, 1'b0, 1, 2, 1'b0, 1'b0);
        run_pkt(4, 0, 1'b0, 2, 2, 1'b0, 1'b0);

        // Reset in the middle of a payload
        fifo.push_back({6'd5, 2'd2});
        repeat (6) fifo.push_back(8'($urandom));
        nb = 0; cyc = 0; done_cnt = 0;
        while (nb < 2 && cyc < BUDGET) begin
            @(negedge clock);
            if (byte_valid) nb++;
            vld_out = (fifo.size() > 0);
            cyc++;
        end
        check("mid_reset_reached", nb, 2);
        reset = 1'b1;
        #1;
        check("mrst_read_enb", int'(read_enb), 0);
        check("mrst_byte_valid", int'(byte_valid), 0);
        check("mrst_rx_busy", int'(rx_busy), 0);
        check("mrst_byte_out", int'(byte_out), 0);
        check("mrst_pkt_len", int'(pkt_len), 0);
        repeat (2) begin
            @(negedge clock);
            if (pkt_done) done_cnt++;
        end
        reset   = 1'b0;
        vld_out = 1'b0;
        fifo.delete();
        repeat (4) begin
            @(negedge clock);
            if (pkt_done) done_cnt++;
        end
        check("mrst_no_done", done_cnt, 0);
        run_pkt(2, 1, 1'b0, 0, 0, 1'b0, 1'b1);

        for (int k = 0; k < 25; k++)
            run_pkt(int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 3, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
